sub_64_seq: RTL and testbench



---
 rtl/sub_64_seq.sv | 150 +++++++++++++++
 tb/tb_sub_64_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sub_64_seq.sv
// Sequential N-bit subtractor: a - b computed as a + ~b + 1, one CHUNK-bit slice per clock.
// Define SUB64_CC_EN to build the zf/sf/of condition-code flags; otherwise they read as 0.
module sub_64_seq #(
  parameter int N     = 64,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] out,
  output logic         cout,
  output logic         zf,
  output logic         sf,
  output logic         of
);

  localparam int NS = N / CHUNK;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   out_q, out_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           done_q, done_d;
  logic           fin;
  int             shamt;
  logic [CHUNK-1:0] a_sl, b_sl;
  logic [CHUNK:0]   sum;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    fin     = 1'b0;
    shamt   = int'(cnt_q) * CHUNK;
    a_sl    = CHUNK'(a_q >> shamt);
    b_sl    = CHUNK'(b_q >> shamt);
    sum     = {1'b0, a_sl} + {1'b0, b_sl} + (CHUNK+1)'(carry_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = ~b;
          carry_d = 1'b1;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Accumulator is cleared on accept, so OR-ing in each slice is a write.
        acc_d   = acc_q | (N'(sum[CHUNK-1:0]) << shamt);
        carry_d = sum[CHUNK];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(NS - 1)) begin
          fin     = 1'b1;
          out_d   = acc_d;
          cout_d  = sum[CHUNK];
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign out  = out_q;
  assign cout = cout_q;

`ifdef SUB64_CC_EN
  logic zf_q, zf_d, sf_q, sf_d, of_q, of_d;

  // b_q holds ~b, so equal top bits of a_q and b_q mean the original signs differed.
  always_comb begin
    zf_d = zf_q;
    sf_d = sf_q;
    of_d = of_q;
    if (fin) begin
      zf_d = (acc_d == '0);
      sf_d = acc_d[N-1];
      of_d = (a_q[N-1] == b_q[N-1]) && (acc_d[N-1] != a_q[N-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q <= 1'b0;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else begin
      zf_q <= zf_d;
      sf_q <= sf_d;
      of_q <= of_d;
    end
  end

  assign zf = zf_q;
  assign sf = sf_q;
  assign of = of_q;
`else
  assign zf = 1'b0;
  assign sf = 1'b0;
  assign of = 1'b0;
`endif

endmodule

// File: tb/tb_sub_64_seq.sv
// Randomized self-checking bench for sub_64_seq against a plain-arithmetic reference model.
module tb_sub_64_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [63:0] a_i, b_i;
  logic        busy, done, cout, zf, sf, of;
  logic [63:0] out;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [63:0] prev_out = '0;

  sub_64_seq #(.N(64), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i),
    .busy(busy), .done(done), .out(out), .cout(cout),
    .zf(zf), .sf(sf), .of(of)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: wide signed/unsigned arithmetic, no slicing.
  task automatic model(input logic [63:0] x, input logic [63:0] y, output logic [63:0] o,
                       output logic c, output logic z, output logic s, output logic v);
    logic signed [64:0] sd;
    o  = x - y;
    c  = (x >= y);
    sd = $signed({x[63], x}) - $signed({y[63], y});
`ifdef SUB64_CC_EN
    z = (o == 64'd0);
    s = o[63];
    v = (sd > 65'sd9223372036854775807) || (sd < -65'sd9223372036854775808);
`else
    z = 1'b0;
    s = 1'b0;
    v = (sd != sd);
`endif
  endtask

  // Waits for done (bounded); optionally raises/lowers start at given cycle numbers.
  task automatic wait_done(output int cyc, input int set_at, input int clr_at);
    cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == set_at) start = 1'b1;
      if (cyc == clr_at) start = 1'b0;
      if (done) break;
      check_eq("hold_out", out, prev_out);
      if (cyc >= 20) begin
        check_eq("done_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [63:0] x, input logic [63:0] y);
    logic [63:0] eo;
    logic ec, ez, es, ev;
    model(x, y, eo, ec, ez, es, ev);
    check_eq({tag, "_out"},  out,  eo);
    check_eq({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
    check_eq({tag, "_zf"},   {63'd0, zf},   {63'd0, ez});
    check_eq({tag, "_sf"},   {63'd0, sf},   {63'd0, es});
    check_eq({tag, "_of"},   {63'd0, of},   {63'd0, ev});
    check_eq({tag, "_busy"}, {63'd0, busy}, 64'd0);
    prev_out = eo;
  endtask

  task automatic run_op(input string tag, input logic [63:0] x, input logic [63:0] y);
    int cyc;
    @(negedge clk);
    a_i = x; b_i = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq({tag, "_busy_e0"}, {63'd0, busy}, 64'd1);
    a_i = {$urandom, $urandom};
    b_i = {$urandom, $urandom};
    wait_done(cyc, 3, 4);
    check_eq({tag, "_latency"}, 64'(cyc), 64'd8);
    check_result(tag, x, y);
    @(posedge clk); #1;
    check_eq({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    $display("op %s a=%h b=%h out=%h cout=%0d zf=%0d sf=%0d of=%0d", tag, x, y, out, cout, zf, sf, of);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'h8000_0000_0000_0000;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'(32'($urandom_range(0, 300)));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int cyc;
    logic seen;
    logic [63:0] x1, y1, x2, y2;
    rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_out",  out, 64'd0);
    check_eq("rst_flags", {60'd0, cout, zf, sf, of}, 64'd0);
    @(negedge clk); rst = 1'b0;

    run_op("basic",   64'd10, 64'd3);
    run_op("borrow",  64'd3,  64'd10);
    run_op("zero",    64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    run_op("xslice",  64'h100, 64'd1);
    run_op("ovf_neg", 64'h8000_0000_0000_0000, 64'd1);
    run_op("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);

    // Back-to-back: start held through the done cycle.
    x1 = {$urandom, $urandom}; y1 = {$urandom, $urandom};
    x2 = {$urandom, $urandom}; y2 = {$urandom, $urandom};
    @(negedge clk);
    a_i = x1; b_i = y1; start = 1'b1;
    @(posedge clk); #1;
    a_i = x2; b_i = y2;
    wait_done(cyc, -1, -1);
    check_eq("b2b_lat1", 64'(cyc), 64'd8);
    check_result("b2b1", x1, y1);
    wait_done(cyc, -1, 1);
    check_eq("b2b_lat2", 64'(cyc), 64'd9);
    check_result("b2b2", x2, y2);
    $display("op b2b a=%h b=%h out=%h", x2, y2, out);
    start = 1'b0;

    // Reset in the middle of RUN.
    @(negedge clk);
    a_i = 64'd1000; b_i = 64'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid_rst_busy", {63'd0, busy}, 64'd0);
    check_eq("mid_rst_out",  out, 64'd0);
    check_eq("mid_rst_flags", {60'd0, cout, zf, sf, of}, 64'd0);
    prev_out = '0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check_eq("mid_rst_no_done", {63'd0, seen}, 64'd0);
    $display("op mid_rst busy=%0d out=%h", busy, out);

    // Reset and start on the same edge: reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a_i = 64'd5; b_i = 64'd2;
    @(posedge clk); #1;
    check_eq("rst_vs_start_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0; start = 1'b0;
    $display("op rst_start busy=%0d", busy);

    run_op("post_rst", 64'd55, 64'd77);

    for (int i = 0; i < 30; i++) begin
      run_op($sformatf("rnd%0d", i), pick(), pick());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
